irq_sched: RTL and testbench

Prioritised interrupt scheduler with claim/complete handshake for the Nios-side CPU, sitting on the Avalon-MM bus beside the peripheral interrupt sources. It synchronises raw peripheral interrupt lines and latches them as edge- or level-type pending bits. It raises a single CPU interrupt and hands out one source at a time through a CLAIM read, blocking further interrupts until software writes COMPLETE.

---
 rtl/irq_sched_pkg.sv | 18 +
 rtl/irq_sched_if.sv | 22 ++
 rtl/irq_sched_prio_enc.sv | 25 ++
 rtl/irq_sched.sv | 96 +++++++++
 tb/tb_irq_sched.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_sched_pkg.sv
// Shared register map, FSM state type and claim-id width for irq_sched.
// Pure declarations, no logic.
package irq_sched_pkg;

    localparam int ID_W = 5;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_MODE     = 3'd2;
    localparam logic [2:0] ADDR_CLAIM    = 3'd3;
    localparam logic [2:0] ADDR_COMPLETE = 3'd4;

    typedef enum logic {
        IDLE      = 1'b0,
        SERVICING = 1'b1
    } state_t;

endpackage

// File: rtl/irq_sched_if.sv
// Avalon-MM slave bus plus CPU interrupt line between the Nios CPU and irq_sched.
// Zero-wait-state reads; the slave never stalls the master.
interface irq_sched_if;

    logic [2:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        avl_irq;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata,
        input  avl_readdata, avl_irq
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata,
        output avl_readdata, avl_irq
    );

endinterface

// File: rtl/irq_sched_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit.
// Combinational, no backpressure.
module prio_enc
    import irq_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Prioritised interrupt scheduler with claim/complete handshake on Avalon-MM.
// Sources reach pending 2-3 clk after the raw line; reads are zero-wait, no backpressure.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int NIRQ = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_src,
    irq_sched_if.slave      bus
);

    logic [NIRQ-1:0] sync_q, s, s_d;
    logic [NIRQ-1:0] pending, enable, mode;
    logic [NIRQ-1:0] req, rise, w1c_clr, claim_clr, pending_nxt;
    logic [ID_W-1:0] cur_id, win_idx;
    logic            win_vld;
    logic            claim_go, complete_go;
    state_t          state;

    assign req = pending & enable;

    prio_enc #(.N(NIRQ)) u_prio_enc (
        .req   (req),
        .valid (win_vld),
        .idx   (win_idx)
    );

    assign claim_go    = bus.avl_read && (bus.avl_address == ADDR_CLAIM) &&
                         (state == IDLE) && win_vld;
    assign complete_go = bus.avl_write && (bus.avl_address == ADDR_COMPLETE) &&
                         (state == SERVICING) &&
                         (bus.avl_writedata[ID_W-1:0] == cur_id + ID_W'(1));

    assign rise      = s & ~s_d;
    assign w1c_clr   = (bus.avl_write && (bus.avl_address == ADDR_PENDING)) ?
                       bus.avl_writedata[NIRQ-1:0] : '0;
    assign claim_clr = claim_go ? (NIRQ'(1) << win_idx) : '0;

    // A new edge outranks any clear of the same bit; level bits just mirror s.
    assign pending_nxt = (mode & (rise | (pending & ~(w1c_clr | claim_clr)))) |
                         (~mode & s);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            s       <= '0;
            s_d     <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
            state   <= IDLE;
            cur_id  <= '0;
        end else begin
            sync_q  <= irq_src;
            s       <= sync_q;
            s_d     <= s;
            pending <= pending_nxt;
            if (bus.avl_write && (bus.avl_address == ADDR_ENABLE))
                enable <= bus.avl_writedata[NIRQ-1:0];
            if (bus.avl_write && (bus.avl_address == ADDR_MODE))
                mode <= bus.avl_writedata[NIRQ-1:0];
            case (state)
                IDLE: begin
                    if (claim_go) begin
                        state  <= SERVICING;
                        cur_id <= win_idx;
                    end
                end
                SERVICING: begin
                    if (complete_go)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.avl_readdata = '0;
        case (bus.avl_address)
            ADDR_PENDING: bus.avl_readdata[NIRQ-1:0] = pending;
            ADDR_ENABLE:  bus.avl_readdata[NIRQ-1:0] = enable;
            ADDR_MODE:    bus.avl_readdata[NIRQ-1:0] = mode;
            ADDR_CLAIM: begin
                if ((state == IDLE) && win_vld)
                    bus.avl_readdata = {{(32-ID_W){1'b0}}, win_idx} + 32'd1;
            end
            default: bus.avl_readdata = '0;
        endcase
    end

    assign bus.avl_irq = (state == IDLE) && win_vld;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: register map, edge/level claim flow, ignored
// completes, edge-vs-W1C race and reset during service.
module tb_irq_sched;

    logic       clk;
    logic       rst;
    logic [7:0] irq_src;
    int         tests_run;
    int         tests_failed;

    irq_sched_if bus();

    irq_sched #(.NIRQ(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.avl_address = a;
        bus.avl_read    = 1'b1;
        #4;
        d = bus.avl_readdata;
        @(posedge clk);
        #1;
        bus.avl_read    = 1'b0;
        bus.avl_address = 3'd7;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avl_address   = a;
        bus.avl_writedata = d;
        bus.avl_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avl_write     = 1'b0;
        bus.avl_writedata = 32'h0;
        bus.avl_address   = 3'd7;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        irq_src = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            tests_run++;
            if (d !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0);
            end
        end
        tests_run++;
        if (bus.avl_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %b expected 0", bus.avl_irq);
        end
    endtask

    task automatic test_edge_priority();
        logic [31:0] d;
        apply_reset();
        wr(3'd2, 32'hFF);
        wr(3'd1, 32'h05);
        irq_src = 8'h04;
        tick(1);
        irq_src = 8'h01;
        tick(1);
        irq_src = 8'h00;
        tick(4);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_irq_high: got %b expected 1", bus.avl_irq);
        end
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'h05) begin
            tests_failed++;
            $display("FAIL edge_pending: got %h expected %h", d, 32'h05);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL edge_claim_first: got %h expected %h", d, 32'h1);
        end
        tests_run++;
        if (bus.avl_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_irq_after_claim: got %b expected 0", bus.avl_irq);
        end
        wr(3'd4, 32'h1);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_irq_after_complete: got %b expected 1", bus.avl_irq);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h3) begin
            tests_failed++;
            $display("FAIL edge_claim_second: got %h expected %h", d, 32'h3);
        end
        wr(3'd4, 32'h3);
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'h00) begin
            tests_failed++;
            $display("FAIL edge_pending_final: got %h expected %h", d, 32'h00);
        end
        tests_run++;
        if (bus.avl_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_irq_final: got %b expected 0", bus.avl_irq);
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        apply_reset();
        irq_src = 8'h10;
        wr(3'd1, 32'h10);
        wr(3'd2, 32'h00);
        tick(3);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL level_irq_high: got %b expected 1", bus.avl_irq);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h5) begin
            tests_failed++;
            $display("FAIL level_claim: got %h expected %h", d, 32'h5);
        end
        tests_run++;
        if (bus.avl_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL level_irq_drop: got %b expected 0", bus.avl_irq);
        end
        wr(3'd4, 32'h5);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL level_irq_reassert: got %b expected 1", bus.avl_irq);
        end
        wr(3'd0, 32'h10);
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'h10) begin
            tests_failed++;
            $display("FAIL level_w1c_ignored: got %h expected %h", d, 32'h10);
        end
        irq_src = 8'h00;
        tick(3);
    endtask

    task automatic test_servicing();
        logic [31:0] d;
        apply_reset();
        wr(3'd2, 32'h24);
        wr(3'd1, 32'h24);
        irq_src = 8'h24;
        tick(1);
        irq_src = 8'h00;
        tick(4);
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h3) begin
            tests_failed++;
            $display("FAIL svc_claim: got %h expected %h", d, 32'h3);
        end
        wr(3'd4, 32'h7);
        tests_run++;
        if (bus.avl_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL svc_bad_complete_irq: got %b expected 0", bus.avl_irq);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL svc_second_claim: got %h expected %h", d, 32'h0);
        end
        wr(3'd4, 32'h3);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL svc_complete_irq: got %b expected 1", bus.avl_irq);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h6) begin
            tests_failed++;
            $display("FAIL svc_claim_next: got %h expected %h", d, 32'h6);
        end
        wr(3'd4, 32'h6);
    endtask

    task automatic test_edge_vs_w1c();
        logic [31:0] d;
        apply_reset();
        wr(3'd2, 32'h02);
        irq_src = 8'h02;
        tick(2);
        // This write lands on the same edge that latches the new rising edge.
        wr(3'd0, 32'h02);
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'h02) begin
            tests_failed++;
            $display("FAIL race_set_wins: got %h expected %h", d, 32'h02);
        end
        wr(3'd0, 32'h02);
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'h00) begin
            tests_failed++;
            $display("FAIL race_w1c_later: got %h expected %h", d, 32'h00);
        end
        irq_src = 8'h00;
        tick(3);
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        apply_reset();
        wr(3'd2, 32'h08);
        wr(3'd1, 32'h08);
        irq_src = 8'h08;
        tick(1);
        irq_src = 8'h00;
        tick(4);
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL rst_svc_claim: got %h expected %h", d, 32'h4);
        end
        apply_reset();
        rd(3'd1, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_svc_enable: got %h expected %h", d, 32'h0);
        end
        rd(3'd2, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_svc_mode: got %h expected %h", d, 32'h0);
        end
        wr(3'd2, 32'h08);
        wr(3'd1, 32'h08);
        irq_src = 8'h08;
        tick(1);
        irq_src = 8'h00;
        tick(4);
        tests_run++;
        if (bus.avl_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_svc_irq: got %b expected 1", bus.avl_irq);
        end
        rd(3'd3, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL rst_svc_reclaim: got %h expected %h", d, 32'h4);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        irq_src           = 8'h00;
        bus.avl_address   = 3'd7;
        bus.avl_read      = 1'b0;
        bus.avl_write     = 1'b0;
        bus.avl_writedata = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_edge_priority();
        test_level();
        test_servicing();
        test_edge_vs_w1c();
        test_reset_mid_service();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
